// File: rtl/ram_pkg.sv
// Shared types and constants for the latency-configurable backing RAM.
package ram_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  localparam int LATENCY_MAX = 255;
  localparam int STAT_WIDTH  = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v,
                                                    input logic                  en);
    if (en && (v != {STAT_WIDTH{1'b1}})) begin
      sat_inc = v + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = v;
    end
  endfunction

endpackage

// File: rtl/lat_ram_stats.sv
// Saturating read/write/abort event counters for lat_ram (built only with RAM_STATS_EN).
module lat_ram_stats
  import ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_evt,
  input  logic                  wr_evt,
  input  logic                  abort_evt,
  output logic [STAT_WIDTH-1:0] rd_count,
  output logic [STAT_WIDTH-1:0] wr_count,
  output logic [STAT_WIDTH-1:0] abort_count
);

  logic [STAT_WIDTH-1:0] rd_q, rd_d;
  logic [STAT_WIDTH-1:0] wr_q, wr_d;
  logic [STAT_WIDTH-1:0] ab_q, ab_d;

  // Next counter values.
  always_comb begin
    rd_d = sat_inc(rd_q, rd_evt);
    wr_d = sat_inc(wr_q, wr_evt);
    ab_d = sat_inc(ab_q, abort_evt);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= {STAT_WIDTH{1'b0}};
      wr_q <= {STAT_WIDTH{1'b0}};
      ab_q <= {STAT_WIDTH{1'b0}};
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      ab_q <= ab_d;
    end
  end

  assign rd_count    = rd_q;
  assign wr_count    = wr_q;
  assign abort_count = ab_q;

endmodule

// File: rtl/lat_ram.sv
// Word-addressed RAM answering one cs/ack transaction after a fixed LATENCY.
// Define RAM_STATS_EN to add rd_count/wr_count/abort_count outputs.
module lat_ram
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  ack
`ifdef RAM_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] rd_count,
  output logic [STAT_WIDTH-1:0] wr_count,
  output logic [STAT_WIDTH-1:0] abort_count
`endif
);

  localparam int WORDS   = 2 ** ADDR_WIDTH;
  localparam int LAT_EFF = (LATENCY < 1) ? 1 : ((LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY);
  localparam logic [7:0] CNT_INIT = 8'(LAT_EFF - 1);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    mem_wr_s;
  logic [DATA_WIDTH-1:0]   mem_q [WORDS];
  logic                    unused_addr_bits;

  // Upper address bits alias; byte-lane bits are ignored.
  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  // Handshake FSM next-state and access decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    idx_d    = idx_q;
    din_d    = din_q;
    dout_d   = dout_q;
    mem_wr_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs) begin
          we_d    = we;
          idx_d   = addr[ADDR_WIDTH+1:2];
          din_d   = din;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!cs) begin
          state_d = S_IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = S_ACK;
          if (we_q) begin
            mem_wr_s = 1'b1;
          end else begin
            dout_d = mem_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      // cs is ignored here so a held request cannot be accepted twice.
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and transaction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      idx_q   <= {ADDR_WIDTH{1'b0}};
      din_q   <= {DATA_WIDTH{1'b0}};
      dout_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
    end
  end

  // Storage array; contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && mem_wr_s) begin
      mem_q[idx_q] <= din_q;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q == S_WAIT);
  assign ack  = (state_q == S_ACK);

`ifdef RAM_STATS_EN
  logic rd_evt_s, wr_evt_s, abort_evt_s;

  assign rd_evt_s    = (state_q == S_ACK) && !we_q;
  assign wr_evt_s    = (state_q == S_ACK) && we_q;
  assign abort_evt_s = (state_q == S_WAIT) && !cs;

  lat_ram_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .rd_evt     (rd_evt_s),
    .wr_evt     (wr_evt_s),
    .abort_evt  (abort_evt_s),
    .rd_count   (rd_count),
    .wr_count   (wr_count),
    .abort_count(abort_count)
  );
`endif

endmodule
